// File: rtl/shift_iter.sv
// shift_iter: multi-cycle shifter, one bit position per clock.
// Controller handshake: start in IDLE, busy while active, one-cycle done.
module shift_iter #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [CW-1:0]    amt,
    output logic [WIDTH-1:0] sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sout_q;
    logic [WIDTH-1:0] sout_d;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    // Single-position step of the captured operation.
    always_comb begin
        sout_d = sout_q;
        unique case (op_q)
            2'b01:   sout_d = {sout_q[WIDTH-2:0], 1'b0};
            2'b10:   sout_d = {1'b0, sout_q[WIDTH-1:1]};
            2'b11:   sout_d = {sout_q[WIDTH-1], sout_q[WIDTH-1:1]};
            default: sout_d = sout_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sout_q  <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sout_q <= in;
                        op_q   <= shift;
                        cnt_q  <= amt;
                        busy_q <= 1'b1;
                        // Zero-length work skips straight to the done pulse.
                        if (amt == '0 || shift == 2'b00) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sout_q <= sout_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
